// File: rtl/ddr_judge.sv
// ddr_judge: per-lane timing judge for target pulses vs. button presses, with saturating score and combo.
// Define DDR_JUDGE_BOO_EN to penalise presses on idle lanes (boo pulse, -1 score, combo reset).
module ddr_judge #(
  parameter int WINDOW  = 500,
  parameter int PERFECT = 150
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        start,
  input  logic        left,
  input  logic        right,
  input  logic        up,
  input  logic        down,
  input  logic [3:0]  btn,
  output logic [3:0]  hit_perfect,
  output logic [3:0]  hit_good,
  output logic [3:0]  miss,
  output logic [3:0]  boo,
  output logic [15:0] score,
  output logic [7:0]  combo,
  output logic [7:0]  max_combo
);

`ifdef DDR_JUDGE_BOO_EN
  localparam bit BOO_EN = 1'b1;
`else
  localparam bit BOO_EN = 1'b0;
`endif

  localparam logic [9:0] CNT_LAST = 10'(WINDOW - 1);
  localparam logic [9:0] CNT_PERF = 10'(PERFECT);

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} lane_state_t;

  lane_state_t state_q [4];
  lane_state_t state_d [4];
  logic [9:0]  cnt_q [4];
  logic [9:0]  cnt_d [4];
  logic [3:0]  btn_q;
  logic [3:0]  press;
  logic [3:0]  target;
  logic [3:0]  perf_d, good_d, miss_d, boo_d;
  logic [2:0]  n_hit;
  logic [17:0] credit;
  logic [17:0] debit;
  logic [8:0]  combo_sum;
  logic [15:0] score_d;
  logic [7:0]  combo_d;

  assign target = {down, up, right, left};
  assign press  = btn & ~btn_q;

  function automatic logic [2:0] pop4(input logic [3:0] v);
    return {2'b0, v[0]} + {2'b0, v[1]} + {2'b0, v[2]} + {2'b0, v[3]};
  endfunction

  always_comb begin
    perf_d = '0;
    good_d = '0;
    miss_d = '0;
    boo_d  = '0;
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (start) begin
        state_d[i] = IDLE;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          IDLE: begin
            // A target and press landing together count as dead-on.
            if (target[i] && press[i]) begin
              perf_d[i] = 1'b1;
            end else if (target[i]) begin
              state_d[i] = PENDING;
              cnt_d[i]   = '0;
            end else if (press[i]) begin
              boo_d[i] = BOO_EN;
            end
          end
          PENDING: begin
            if (press[i]) begin
              if (cnt_q[i] < CNT_PERF) perf_d[i] = 1'b1;
              else                     good_d[i] = 1'b1;
              state_d[i] = target[i] ? PENDING : IDLE;
              cnt_d[i]   = '0;
            end else if (target[i]) begin
              miss_d[i] = 1'b1;
              cnt_d[i]  = '0;
            end else if (tick) begin
              if (cnt_q[i] == CNT_LAST) begin
                miss_d[i]  = 1'b1;
                state_d[i] = IDLE;
                cnt_d[i]   = '0;
              end else begin
                cnt_d[i] = cnt_q[i] + 10'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end

    // Credits and boo debits are netted before saturating in either direction.
    n_hit  = pop4(perf_d) + pop4(good_d);
    credit = {2'b0, score} + {14'b0, pop4(perf_d), 1'b0} + {15'b0, pop4(good_d)};
    debit  = {15'b0, pop4(boo_d)};
    if (start)                          score_d = '0;
    else if (credit < debit)            score_d = '0;
    else if (credit - debit > 18'd65535) score_d = 16'hFFFF;
    else                                score_d = 16'(credit - debit);

    combo_sum = {1'b0, combo} + {6'b0, n_hit};
    if (start || (|miss_d) || (|boo_d)) combo_d = '0;
    else if (combo_sum[8])              combo_d = 8'hFF;
    else                                combo_d = combo_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      btn_q       <= '0;
      hit_perfect <= '0;
      hit_good    <= '0;
      miss        <= '0;
      boo         <= '0;
      score       <= '0;
      combo       <= '0;
      max_combo   <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      btn_q       <= btn;
      hit_perfect <= perf_d;
      hit_good    <= good_d;
      miss        <= miss_d;
      boo         <= boo_d;
      score       <= score_d;
      combo       <= combo_d;
      if (combo > max_combo) max_combo <= combo;
    end
  end

endmodule
